// File: rtl/com_frame_tx.sv
// com_frame_tx -- byte-serial frame transmitter.
//
// Sends one frame per start request. Each frame is a preamble, an SOF byte,
// a type byte, a 16-bit big-endian length, the payload read from a RAM with
// one cycle of read latency, and an optional 8-bit checksum byte.
//
// Compile-time option:
//   COM_TX_CSUM_EN  defined   -> CSUM byte (mod-256 sum of HEAD, LENH, LENL
//                                and payload) follows the last payload byte.
//                   undefined -> frame ends after the payload (or LENL).
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   fs             frame start request (level)
//   fd             frame done (level, high in DONE only)
//   btype          frame type, sampled at start
//   tx_dlen        payload byte count, sampled at start
//   ram_addr_init  first payload address, sampled at start
//   ram_rxa        RAM read address
//   ram_rxd        RAM read data, valid one cycle after ram_rxa
//   com_txd        transmit byte
//   com_txv        com_txd valid
//   tx_rdy         downstream accept; transfer when com_txv && tx_rdy
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for fs; com_txv low
// PRE    | sending PRE_N preamble bytes (8'h55)
// SOF    | sending start-of-frame byte (8'hD5)
// HEAD   | sending zero-extended btype
// LENH   | sending length[15:8]; first payload prefetch issued on exit
// LENL   | sending length[7:0]
// DATA   | sending payload bytes
// CSUM   | sending checksum byte (only with COM_TX_CSUM_EN)
// DONE   | fd high, com_txv low; back to IDLE once fs is low

module com_frame_tx #(
  parameter int ADDR_W  = 12,
  parameter int LEN_W   = 12,
  parameter int BTYPE_W = 4,
  parameter int PRE_N   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fs,
  output logic               fd,
  input  logic [BTYPE_W-1:0] btype,
  input  logic [LEN_W-1:0]   tx_dlen,
  input  logic [ADDR_W-1:0]  ram_addr_init,
  output logic [ADDR_W-1:0]  ram_rxa,
  input  logic [7:0]         ram_rxd,
  output logic [7:0]         com_txd,
  output logic               com_txv,
  input  logic               tx_rdy
);

  localparam int PRE_CW = (PRE_N > 1) ? $clog2(PRE_N) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SOF, S_HEAD, S_LENH, S_LENL, S_DATA, S_CSUM, S_DONE
  } state_t;

  state_t             r_state;
  logic [BTYPE_W-1:0] r_btype;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;      // payload bytes left after the one on com_txd
  logic [LEN_W-1:0]   r_iss_rem;  // RAM addresses not yet issued
  logic [ADDR_W-1:0]  r_addr0;
  logic [ADDR_W-1:0]  r_rxa;
  logic [PRE_CW-1:0]  r_pre_cnt;
  logic [7:0]         r_txd;
  logic [7:0]         r_skid;
  logic               r_txv;
  logic               r_fd;
  // r_fresh: ram_rxd currently carries the next payload byte. When a stall
  // starts, that byte is parked in r_skid because ram_rxa has already moved
  // one address further on and ram_rxd will follow it.
  logic               r_fresh;
`ifdef COM_TX_CSUM_EN
  logic [7:0]         r_csum;
`endif

  logic               w_xfer;
  logic               w_more;
  logic [7:0]         w_pay;
  logic [7:0]         w_btype8;
  logic [15:0]        w_len16;

  assign w_xfer   = r_txv & tx_rdy;
  assign w_pay    = r_fresh ? ram_rxd : r_skid;
  assign w_btype8 = 8'(r_btype);
  assign w_len16  = 16'(r_len);
  assign w_more   = (r_state == S_LENL) ? (r_len != '0) : (r_cnt != '0);

  assign fd      = r_fd;
  assign com_txd = r_txd;
  assign com_txv = r_txv;
  assign ram_rxa = r_rxa;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_btype   <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_iss_rem <= '0;
      r_addr0   <= '0;
      r_rxa     <= '0;
      r_pre_cnt <= '0;
      r_txd     <= 8'h00;
      r_skid    <= 8'h00;
      r_txv     <= 1'b0;
      r_fd      <= 1'b0;
      r_fresh   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fs) begin
            r_btype   <= btype;
            r_len     <= tx_dlen;
            r_addr0   <= ram_addr_init;
            r_rxa     <= ram_addr_init;
            r_iss_rem <= (tx_dlen == '0) ? '0 : tx_dlen - LEN_W'(1);
            r_pre_cnt <= PRE_CW'(PRE_N - 1);
            r_fresh   <= 1'b0;
            r_txd     <= 8'h55;
            r_txv     <= 1'b1;
            r_state   <= S_PRE;
          end
        end

        S_PRE: begin
          if (w_xfer) begin
            if (r_pre_cnt == '0) begin
              r_txd   <= 8'hD5;
              r_state <= S_SOF;
            end else begin
              r_pre_cnt <= r_pre_cnt - PRE_CW'(1);
            end
          end
        end

        S_SOF: begin
          if (w_xfer) begin
            r_txd   <= w_btype8;
            r_state <= S_HEAD;
          end
        end

        S_HEAD: begin
          if (w_xfer) begin
            r_txd   <= w_len16[15:8];
            r_state <= S_LENH;
          end
        end

        // Moving ram_rxa one ahead here lets DATA run at one byte per cycle
        // despite the RAM's read latency.
        S_LENH: begin
          if (w_xfer) begin
            r_txd   <= w_len16[7:0];
            r_fresh <= 1'b1;
            if (r_iss_rem != '0) begin
              r_rxa     <= r_rxa + ADDR_W'(1);
              r_iss_rem <= r_iss_rem - LEN_W'(1);
            end
            r_state <= S_LENL;
          end
        end

        S_LENL, S_DATA: begin
          if (w_xfer) begin
            r_fresh <= 1'b1;
            if (w_more) begin
              r_txd <= w_pay;
              r_cnt <= (r_state == S_LENL) ? r_len - LEN_W'(1) : r_cnt - LEN_W'(1);
              if (r_iss_rem != '0) begin
                r_rxa     <= r_rxa + ADDR_W'(1);
                r_iss_rem <= r_iss_rem - LEN_W'(1);
              end
              r_state <= S_DATA;
            end else begin
              r_rxa <= r_addr0;
`ifdef COM_TX_CSUM_EN
              // r_csum does not yet include the byte now leaving.
              r_txd   <= r_csum + r_txd;
              r_state <= S_CSUM;
`else
              r_txv   <= 1'b0;
              r_fd    <= 1'b1;
              r_state <= S_DONE;
`endif
            end
          end else if (r_fresh) begin
            r_skid  <= ram_rxd;
            r_fresh <= 1'b0;
          end
        end

        S_CSUM: begin
          if (w_xfer) begin
            r_txv   <= 1'b0;
            r_fd    <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          if (!fs) begin
            r_fd    <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef COM_TX_CSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_csum <= 8'h00;
    end else if (r_state == S_IDLE && fs) begin
      r_csum <= 8'h00;
    end else if (w_xfer && (r_state == S_HEAD || r_state == S_LENH ||
                            r_state == S_LENL || r_state == S_DATA)) begin
      r_csum <= r_csum + r_txd;
    end
  end
`endif

endmodule

// File: tb/tb_com_frame_tx.sv
module tb_com_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs;
  logic        fd;
  logic [3:0]  btype;
  logic [11:0] tx_dlen;
  logic [11:0] ram_addr_init;
  logic [11:0] ram_rxa;
  logic [7:0]  ram_rxd;
  logic [7:0]  com_txd;
  logic        com_txv;
  logic        tx_rdy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0]  mem [0:4095];
  logic [7:0]  cap_q[$];
  int          cap_cyc[$];
  logic [11:0] rxa_log[$];

  com_frame_tx dut (
    .clk           (clk),
    .rst           (rst),
    .fs            (fs),
    .fd            (fd),
    .btype         (btype),
    .tx_dlen       (tx_dlen),
    .ram_addr_init (ram_addr_init),
    .ram_rxa       (ram_rxa),
    .ram_rxd       (ram_rxd),
    .com_txd       (com_txd),
    .com_txv       (com_txv),
    .tx_rdy        (tx_rdy)
  );

  always #5 clk = ~clk;

  // RAM with one cycle of read latency
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    ram_rxd <= mem[ram_rxa];
  end

  // byte monitor: a byte counts when valid and accepted in the same cycle
  always @(negedge clk) begin
    if (com_txv && tx_rdy) begin
      cap_q.push_back(com_txd);
      cap_cyc.push_back(cyc);
    end
    if (com_txv && (rxa_log.size() == 0 || rxa_log[$] != ram_rxa))
      rxa_log.push_back(ram_rxa);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [3:0] bt, input logic [11:0] len,
                             input logic [11:0] addr, input logic hold);
    cap_q.delete();
    cap_cyc.delete();
    rxa_log.delete();
    btype = bt;
    tx_dlen = len;
    ram_addr_init = addr;
    fs = 1'b1;
    tick();
    // later changes must not affect the frame in flight
    btype = ~bt;
    tx_dlen = len ^ 12'h5A5;
    ram_addr_init = addr ^ 12'h0F0;
    if (!hold) fs = 1'b0;
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (fd) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic end_frame();
    fs = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; fs = 1'b0; tx_rdy = 1'b1;
    btype = 4'h0; tx_dlen = 12'h000; ram_addr_init = 12'h0AB;
    repeat (3) tick();
    checks++; if (fd !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b exp=0", fd); end
    checks++; if (com_txv !== 1'b0) begin failures++; $display("FAIL reset_txv got=%b exp=0", com_txv); end
    checks++; if (com_txd !== 8'h00) begin failures++; $display("FAIL reset_txd got=%h exp=00", com_txd); end
    checks++; if (ram_rxa !== 12'h000) begin failures++; $display("FAIL reset_rxa got=%h exp=000", ram_rxa); end
    rst = 1'b0;
    tick();
    checks++; if (com_txv !== 1'b0) begin failures++; $display("FAIL idle_txv got=%b exp=0", com_txv); end
  endtask

  task automatic test_basic();
    logic ok;
    logic [7:0] exp[$];
    exp = '{8'h55, 8'h55, 8'hD5, 8'h03, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03};
`ifdef COM_TX_CSUM_EN
    exp.push_back(8'h0C);  // 03+00+03+01+02+03
`endif
    start_frame(4'h3, 12'd3, 12'h010, 1'b1);
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_timeout got=%b exp=1", ok); end
    checks++; if (cap_q.size() != exp.size()) begin failures++; $display("FAIL basic_len got=%0d exp=%0d", cap_q.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= cap_q.size() || cap_q[i] !== exp[i]) begin
        failures++;
        $display("FAIL basic_byte[%0d] got=%h exp=%h", i, (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp[i]);
      end
    end
    if (cap_q.size() > 0) begin
      checks++;
      if (cap_cyc[$] - cap_cyc[0] != cap_q.size() - 1) begin
        failures++;
        $display("FAIL basic_b2b got=%0d exp=%0d", cap_cyc[$] - cap_cyc[0], cap_q.size() - 1);
      end
    end
    checks++; if (fd !== 1'b1 || com_txv !== 1'b0) begin failures++; $display("FAIL basic_done got=fd%b/txv%b exp=fd1/txv0", fd, com_txv); end
    end_frame();
    checks++; if (fd !== 1'b0) begin failures++; $display("FAIL basic_fd_drop got=%b exp=0", fd); end
  endtask

  task automatic test_zero_len();
    logic ok;
    logic [7:0] exp[$];
    exp = '{8'h55, 8'h55, 8'hD5, 8'h05, 8'h00, 8'h00};
`ifdef COM_TX_CSUM_EN
    exp.push_back(8'h05);
`endif
    start_frame(4'h5, 12'd0, 12'h010, 1'b1);
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL zlen_timeout got=%b exp=1", ok); end
    checks++; if (cap_q.size() != exp.size()) begin failures++; $display("FAIL zlen_len got=%0d exp=%0d", cap_q.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= cap_q.size() || cap_q[i] !== exp[i]) begin
        failures++;
        $display("FAIL zlen_byte[%0d] got=%h exp=%h", i, (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp[i]);
      end
    end
    checks++; if (ram_rxa !== 12'h010) begin failures++; $display("FAIL zlen_rxa got=%h exp=010", ram_rxa); end
    end_frame();
  endtask

  task automatic test_wrap();
    logic ok;
    logic [7:0]  exp[$];
    logic [11:0] exp_a[$];
    exp   = '{8'h55, 8'h55, 8'hD5, 8'h0A, 8'h00, 8'h04, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    exp_a = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
`ifdef COM_TX_CSUM_EN
    exp.push_back(8'h98);
`endif
    // fs released right after start: the frame must still complete
    start_frame(4'hA, 12'd4, 12'hFFE, 1'b0);
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wrap_timeout got=%b exp=1", ok); end
    checks++; if (cap_q.size() != exp.size()) begin failures++; $display("FAIL wrap_len got=%0d exp=%0d", cap_q.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= cap_q.size() || cap_q[i] !== exp[i]) begin
        failures++;
        $display("FAIL wrap_byte[%0d] got=%h exp=%h", i, (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rxa_log.size() || rxa_log[i] !== exp_a[i]) begin
        failures++;
        $display("FAIL wrap_rxa[%0d] got=%h exp=%h", i, (i < rxa_log.size()) ? rxa_log[i] : 12'hxxx, exp_a[i]);
      end
    end
    end_frame();
    checks++; if (fd !== 1'b0) begin failures++; $display("FAIL wrap_fd_drop got=%b exp=0", fd); end
  endtask

  task automatic test_stall();
    logic ok;
    logic [7:0] exp[$];
    exp = '{8'h55, 8'h55, 8'hD5, 8'h06, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef COM_TX_CSUM_EN
    exp.push_back(8'hB4);  // 06+00+04+11+22+33+44
`endif
    start_frame(4'h6, 12'd4, 12'h100, 1'b1);
    for (int i = 0; i < 50; i++) begin
      if (cap_q.size() >= 7) break;
      tick();
    end
    checks++; if (cap_q.size() != 7) begin failures++; $display("FAIL stall_reach got=%0d exp=7", cap_q.size()); end
    checks++; if (com_txd !== 8'h22 || ram_rxa !== 12'h103) begin failures++; $display("FAIL stall_pre got=%h/%h exp=22/103", com_txd, ram_rxa); end
    tx_rdy = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tick();
      checks++;
      if (com_txd !== 8'h22 || ram_rxa !== 12'h103 || com_txv !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d] got=%h/%h/%b exp=22/103/1", s, com_txd, ram_rxa, com_txv);
      end
    end
    tx_rdy = 1'b1;
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL stall_timeout got=%b exp=1", ok); end
    checks++; if (cap_q.size() != exp.size()) begin failures++; $display("FAIL stall_len got=%0d exp=%0d", cap_q.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= cap_q.size() || cap_q[i] !== exp[i]) begin
        failures++;
        $display("FAIL stall_byte[%0d] got=%h exp=%h", i, (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp[i]);
      end
    end
    end_frame();
  endtask

  task automatic test_long();
    logic ok;
    logic [7:0] exp[$];
    logic [7:0] sum;
    exp = '{8'h55, 8'h55, 8'hD5, 8'h0F, 8'h01, 8'h01};
    sum = 8'h0F + 8'h01 + 8'h01;
    for (int k = 0; k < 257; k++) begin
      exp.push_back(8'(12'h200 + k) ^ 8'h5A);
      sum = sum + (8'(12'h200 + k) ^ 8'h5A);
    end
`ifdef COM_TX_CSUM_EN
    exp.push_back(sum);
`endif
    start_frame(4'hF, 12'h101, 12'h200, 1'b1);
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL long_timeout got=%b exp=1", ok); end
    checks++; if (cap_q.size() != exp.size()) begin failures++; $display("FAIL long_len got=%0d exp=%0d", cap_q.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= cap_q.size() || cap_q[i] !== exp[i]) begin
        failures++;
        $display("FAIL long_byte[%0d] got=%h exp=%h", i, (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp[i]);
      end
    end
    if (cap_q.size() > 0) begin
      checks++;
      if (cap_cyc[$] - cap_cyc[0] != cap_q.size() - 1) begin
        failures++;
        $display("FAIL long_b2b got=%0d exp=%0d", cap_cyc[$] - cap_cyc[0], cap_q.size() - 1);
      end
    end
    end_frame();
  endtask

  task automatic test_reset_mid();
    logic ok;
    int n;
    logic [7:0] exp[$];
    exp = '{8'h55, 8'h55, 8'hD5, 8'h03, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03};
`ifdef COM_TX_CSUM_EN
    exp.push_back(8'h0C);
`endif
    start_frame(4'h3, 12'd3, 12'h010, 1'b1);
    for (int i = 0; i < 50; i++) begin
      if (cap_q.size() >= 7) break;
      tick();
    end
    checks++; if (com_txd !== 8'h02) begin failures++; $display("FAIL rmid_pre got=%h exp=02", com_txd); end
    rst = 1'b1;  // fs still high: reset must win
    tick();
    checks++; if (com_txv !== 1'b0 || fd !== 1'b0) begin failures++; $display("FAIL rmid_out got=txv%b/fd%b exp=txv0/fd0", com_txv, fd); end
    checks++; if (com_txd !== 8'h00 || ram_rxa !== 12'h000) begin failures++; $display("FAIL rmid_regs got=%h/%h exp=00/000", com_txd, ram_rxa); end
    rst = 1'b0;
    fs = 1'b0;
    n = cap_q.size();
    repeat (4) tick();
    checks++; if (cap_q.size() != n || com_txv !== 1'b0) begin failures++; $display("FAIL rmid_idle got=%0d/%b exp=%0d/0", cap_q.size(), com_txv, n); end
    start_frame(4'h3, 12'd3, 12'h010, 1'b1);
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rmid_timeout got=%b exp=1", ok); end
    checks++; if (cap_q.size() != exp.size()) begin failures++; $display("FAIL rmid_len got=%0d exp=%0d", cap_q.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= cap_q.size() || cap_q[i] !== exp[i]) begin
        failures++;
        $display("FAIL rmid_byte[%0d] got=%h exp=%h", i, (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp[i]);
      end
    end
    end_frame();
  endtask

  task automatic test_fs_hold();
    logic ok;
    int n;
    start_frame(4'h5, 12'd1, 12'h010, 1'b1);
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL hold_timeout got=%b exp=1", ok); end
    n = cap_q.size();
    for (int s = 0; s < 5; s++) begin
      tick();
      checks++;
      if (fd !== 1'b1 || com_txv !== 1'b0) begin
        failures++;
        $display("FAIL hold_done[%0d] got=fd%b/txv%b exp=fd1/txv0", s, fd, com_txv);
      end
    end
    checks++; if (cap_q.size() != n) begin failures++; $display("FAIL hold_norestart got=%0d exp=%0d", cap_q.size(), n); end
    fs = 1'b0;
    tick();
    checks++; if (fd !== 1'b0) begin failures++; $display("FAIL hold_fd_drop got=%b exp=0", fd); end
    tick();
    checks++; if (com_txv !== 1'b0) begin failures++; $display("FAIL hold_idle got=%b exp=0", com_txv); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fs = 1'b0; tx_rdy = 1'b1;
    btype = 4'h0; tx_dlen = 12'h000; ram_addr_init = 12'h000;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[12'h010] = 8'h01; mem[12'h011] = 8'h02; mem[12'h012] = 8'h03;
    mem[12'hFFE] = 8'hA1; mem[12'hFFF] = 8'hA2;
    mem[12'h000] = 8'hA3; mem[12'h001] = 8'hA4;
    mem[12'h100] = 8'h11; mem[12'h101] = 8'h22;
    mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;

    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_stall();
    test_long();
    test_reset_mid();
    test_fs_hold();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
